// File: rtl/formula_2_sched_pkg.sv
// Shared types for the formula-2 recirculating scheduler:
// pass encoding, in-flight sideband record and small helpers.
package formula_2_sched_pkg;

   localparam int DATA_W = 32;
   localparam int ROOT_W = 16;

   // Which term of sqrt(a + sqrt(b + sqrt(c))) an isqrt issue computes
   typedef enum logic [1:0] {
      P0 = 2'd0,   // sqrt(c)
      P1 = 2'd1,   // sqrt(b + y)
      P2 = 2'd2    // sqrt(a + y)
   } pass_t;

   // Sideband travelling alongside each issue; a and b are needed by later passes
   typedef struct packed {
      pass_t             pass;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } side_t;

   localparam int SIDE_W = $bits(side_t);

   function automatic pass_t next_pass(input pass_t p);
      pass_t n;
      case (p)
         P0:      n = P1;
         P1:      n = P2;
         default: n = P0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/formula_2_recirc_sched_if.sv
// Argument/result bus of the formula-2 scheduler.
// master = producer of arguments and consumer of results; slave = the block.
interface formula_2_recirc_sched_if;
   import formula_2_sched_pkg::*;

   logic              arg_vld;
   logic              arg_rdy;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] c;
   logic              res_vld;
   logic [DATA_W-1:0] res;
   logic              busy;

   modport master (
      output arg_vld, a, b, c,
      input  arg_rdy, res_vld, res, busy
   );

   modport slave (
      input  arg_vld, a, b, c,
      output arg_rdy, res_vld, res, busy
   );

endinterface

// File: rtl/flip_flop_fifo_with_counter.sv
// Register-based show-ahead FIFO with occupancy counter.
// pop_data is the head entry whenever empty = 0; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module flip_flop_fifo_with_counter #(
   parameter int width = 8,
   parameter int depth = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [width-1:0]           push_data,
   input  logic                       pop,
   output logic [width-1:0]           pop_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(depth+1)-1:0] count
);

   localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
   localparam int CNT_W = $clog2(depth + 1);

   logic [width-1:0] mem [0:depth-1];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(depth));
   assign count   = count_reg;
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign pop_data = mem[rd_ptr_reg];

   // Storage write; contents need no reset
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= push_data;
   end

   // Pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop_ok)
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/isqrt.sv
// Pipelined 32-bit integer square root (floor), 16-bit result.
// The 16 digit-recurrence iterations are spread evenly over n_pipe_stages
// registered stages; y_vld follows x_vld by exactly n_pipe_stages cycles.
module isqrt #(
   parameter int n_pipe_stages = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        x_vld,
   input  logic [31:0] x,
   output logic        y_vld,
   output logic [15:0] y
);

   // One radix-4 digit step: op is the remainder, root the partial result
   function automatic logic [63:0] sqrt_step(input logic [31:0] one,
                                             input logic [31:0] op,
                                             input logic [31:0] root);
      logic [31:0] trial;
      trial = root + one;
      if (op >= trial)
         sqrt_step = {op - trial, (root >> 1) + one};
      else
         sqrt_step = {op, root >> 1};
   endfunction

   logic [n_pipe_stages:0] stage_vld;
   logic [31:0]            stage_op   [0:n_pipe_stages];
   logic [31:0]            stage_root [0:n_pipe_stages];

   assign stage_vld[0]  = x_vld;
   assign stage_op[0]   = x;
   assign stage_root[0] = '0;

   generate
      for (genvar gi = 0; gi < n_pipe_stages; gi++) begin : g_stage
         // Iterations [IT_LO, IT_HI) belong to this stage; may be empty for deep pipes
         localparam int IT_LO = (gi * 16) / n_pipe_stages;
         localparam int IT_HI = ((gi + 1) * 16) / n_pipe_stages;

         logic        vld_reg;
         logic [31:0] op_reg;
         logic [31:0] root_reg;
         logic [31:0] op_next;
         logic [31:0] root_next;

         // Combinational iterations assigned to this stage
         always_comb begin
            op_next   = stage_op[gi];
            root_next = stage_root[gi];
            for (int k = IT_LO; k < IT_HI; k++) begin
               {op_next, root_next} = sqrt_step(32'd1 << (30 - 2 * k), op_next, root_next);
            end
         end

         // Stage register; only the valid bit needs clearing
         always_ff @(posedge clk) begin
            if (rst)
               vld_reg <= 1'b0;
            else
               vld_reg <= stage_vld[gi];
            op_reg   <= op_next;
            root_reg <= root_next;
         end

         assign stage_vld[gi+1]  = vld_reg;
         assign stage_op[gi+1]   = op_reg;
         assign stage_root[gi+1] = root_reg;
      end
   endgenerate

   assign y_vld = stage_vld[n_pipe_stages];
   assign y     = stage_root[n_pipe_stages][15:0];

   // Final remainder and the (always zero) upper root bits are not needed
   logic unused_tail;
   assign unused_tail = (|stage_op[n_pipe_stages]) ^ (|stage_root[n_pipe_stages][31:16]);

endmodule

// File: rtl/formula_2_recirc_sched.sv
// Evaluates sqrt(a + sqrt(b + sqrt(c))) with a single pipelined isqrt,
// recirculating each argument set through it three times. A sideband FIFO
// carries {pass, a, b} in lock-step with the isqrt pipeline.
module formula_2_recirc_sched
   import formula_2_sched_pkg::*;
#(
   parameter int ISQRT_STAGES = 16,
   parameter int TAG_DEPTH    = ISQRT_STAGES   // must be >= ISQRT_STAGES
) (
   input logic                      clk,
   input logic                      rst,
   formula_2_recirc_sched_if.slave  bus
);

   localparam int CNT_W  = $clog2(ISQRT_STAGES + 1);
   localparam int FCNT_W = $clog2(TAG_DEPTH + 1);

   logic              x_vld;
   logic [DATA_W-1:0] x;
   logic              y_vld;
   logic [ROOT_W-1:0] y;

   side_t             head;
   side_t             push_side;
   logic [SIDE_W-1:0] pop_data;
   logic              fifo_empty;
   logic              fifo_full;
   logic [FCNT_W-1:0] fifo_count;

   logic              recirc;
   logic              finish;
   logic              accept;
   logic [CNT_W-1:0]  inflight_reg;

   isqrt #(
      .n_pipe_stages (ISQRT_STAGES)
   ) u_isqrt (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (y_vld),
      .y     (y)
   );

   flip_flop_fifo_with_counter #(
      .width (SIDE_W),
      .depth (TAG_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (x_vld),
      .push_data (push_side),
      .pop       (y_vld),
      .pop_data  (pop_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign head = side_t'(pop_data);

   // A returning P0/P1 result owns the isqrt input slot this cycle
   assign recirc = y_vld && (head.pass != P2);
   assign finish = y_vld && (head.pass == P2);
   assign accept = bus.arg_vld && bus.arg_rdy;

   assign bus.arg_rdy = !recirc;
   assign bus.res_vld = finish;
   assign bus.res     = {16'b0, y};
   assign bus.busy    = (inflight_reg != '0);

   // Issue mux: recirculation first, otherwise a newly accepted set
   always_comb begin
      x_vld     = 1'b0;
      x         = '0;
      push_side = '0;
      if (recirc) begin
         x_vld          = 1'b1;
         x              = ((head.pass == P0) ? head.b : head.a) + {16'b0, y};
         push_side.pass = next_pass(head.pass);
         push_side.a    = head.a;
         push_side.b    = head.b;
      end else if (accept) begin
         x_vld          = 1'b1;
         x              = bus.c;
         push_side.pass = P0;
         push_side.a    = bus.a;
         push_side.b    = bus.b;
      end
   end

   // Count of argument sets accepted but not yet returned
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_reg <= '0;
      end else begin
         case ({accept, finish})
            2'b10:   inflight_reg <= inflight_reg + 1'b1;
            2'b01:   inflight_reg <= inflight_reg - 1'b1;
            default: inflight_reg <= inflight_reg;
         endcase
      end
   end

   // FIFO status is fully implied by the pipeline valids; kept for observation
   logic unused_fifo_status;
   assign unused_fifo_status = fifo_empty ^ fifo_full ^ (|fifo_count);

endmodule

// File: tb/tb_formula_2_recirc_sched.sv
// Self-checking bench for formula_2_recirc_sched (default 16 isqrt stages).
module tb_formula_2_recirc_sched;

   localparam int STAGES = 16;
   localparam int LAT    = 3 * STAGES;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] exp_res;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   formula_2_recirc_sched_if bus ();

   formula_2_recirc_sched #(
      .ISQRT_STAGES (STAGES),
      .TAG_DEPTH    (STAGES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int  checks = 0;
   int  errors = 0;
   int  cycle  = 0;
   int  n_accepts = 0;
   int  n_results = 0;
   sb_t exp_q[$];
   vec_t vecs[6];

   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
      logic [15:0] r;
      logic [15:0] cand;
      logic [63:0] sq;
      r = '0;
      for (int i = 15; i >= 0; i--) begin
         cand = r | (16'd1 << i);
         sq   = 64'(cand) * 64'(cand);
         if (sq <= 64'(v)) r = cand;
      end
      return r;
   endfunction

   function automatic logic [31:0] ref_formula(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c);
      logic [31:0] s;
      logic [15:0] y;
      y = ref_isqrt(c);
      s = b + {16'b0, y};
      y = ref_isqrt(s);
      s = a + {16'b0, y};
      return {16'b0, ref_isqrt(s)};
   endfunction

   // Scoreboard and FIFO-safety monitor
   always @(negedge clk) begin
      sb_t e;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (bus.res_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_res: res_vld=1 res=%0d with no set in flight (cycle %0d)", bus.res, cycle);
            end else begin
               e = exp_q.pop_front();
               n_results++;
               if (bus.res !== e.res) begin
                  errors++;
                  $display("FAIL sb_res: got %0d expected %0d (cycle %0d)", bus.res, e.res, cycle);
               end
               checks++;
               if (cycle - e.cyc != LAT) begin
                  errors++;
                  $display("FAIL sb_latency: got %0d expected %0d", cycle - e.cyc, LAT);
               end
            end
         end
         if (bus.arg_vld && bus.arg_rdy) begin
            e.res = ref_formula(bus.a, bus.b, bus.c);
            e.cyc = cycle;
            exp_q.push_back(e);
            n_accepts++;
         end
         if (dut.y_vld) begin
            checks++;
            if (dut.fifo_empty) begin
               errors++;
               $display("FAIL fifo_underflow: y_vld with empty sideband FIFO (cycle %0d)", cycle);
            end
         end
         if (dut.x_vld && dut.fifo_full && !dut.y_vld) begin
            checks++;
            errors++;
            $display("FAIL fifo_overflow: push into full sideband FIFO (cycle %0d)", cycle);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      bus.arg_vld = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (bus.busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.busy) begin
         errors++;
         $display("FAIL %s_drain: busy still 1 after %0d cycles", name, n);
      end
   endtask

   // One argument set issued on an idle block; measures latency, result and busy width
   task automatic single_set(input int idx, input vec_t v);
      int lat;
      int busy_cycles;
      logic [31:0] got;
      logic seen;
      @(posedge clk); #1;
      bus.arg_vld = 1'b1;
      bus.a = v.a; bus.b = v.b; bus.c = v.c;
      @(negedge clk);
      check("single_arg_rdy", 32'(bus.arg_rdy), 32'd1);
      @(posedge clk); #1;
      bus.arg_vld = 1'b0;
      lat = 0; busy_cycles = 0; seen = 1'b0; got = '0;
      while (!seen && lat < 200) begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_cycles++;
         if (bus.res_vld) begin
            seen = 1'b1;
            got  = bus.res;
         end
      end
      check("single_latency", 32'(lat), 32'(LAT));
      check("single_res", got, v.exp_res);
      check("single_busy_width", 32'(busy_cycles), 32'(LAT));
      @(negedge clk);
      check("single_busy_after", 32'(bus.busy), 32'd0);
      $display("set %0d: a=%0d b=%0d c=%0d -> res=%0d (exp %0d) latency=%0d", idx, v.a, v.b, v.c,
               got, v.exp_res, lat);
   endtask

   initial begin
      int idx;
      int res_cnt;
      int sent;
      int guard;
      int acc0;
      int res0;

      vecs[0] = '{a: 32'd9,       b: 32'd12,          c: 32'd16,          exp_res: 32'd3};
      vecs[1] = '{a: 32'd7,       b: 32'd3,           c: 32'd1,           exp_res: 32'd3};
      vecs[2] = '{a: 32'd0,       b: 32'd0,           c: 32'd0,           exp_res: 32'd0};
      vecs[3] = '{a: 32'd0,       b: 32'hFFFF_0000,   c: 32'hFFFF_FFFF,   exp_res: 32'd255};
      vecs[4] = '{a: 32'd0,       b: 32'd0,           c: 32'hFFFF_FFFF,   exp_res: 32'd15};
      vecs[5] = '{a: 32'd1000000, b: 32'd81,          c: 32'd0,           exp_res: 32'd1000};

      bus.arg_vld = 1'b0;
      bus.a = '0; bus.b = '0; bus.c = '0;

      // Reset state
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_res_vld", 32'(bus.res_vld), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_arg_rdy", 32'(bus.arg_rdy), 32'd1);

      // Directed single sets
      for (int i = 0; i < 6; i++) single_set(i, vecs[i]);

      // Continuous arg_vld from reset: 16 accept / 32 stall pattern
      do_reset();
      bus.arg_vld = 1'b1;
      for (int i = 0; i < 64; i++) begin
         bus.a = $urandom; bus.b = $urandom; bus.c = $urandom;
         @(negedge clk);
         check("stream_arg_rdy", 32'(bus.arg_rdy), 32'((i < 16) || (i >= 48)));
         check("stream_res_vld", 32'(bus.res_vld), 32'(i >= 48));
         $display("stream cycle %0d: arg_rdy=%0d res_vld=%0d res=%0d", i, bus.arg_rdy, bus.res_vld, bus.res);
         @(posedge clk); #1;
      end
      bus.arg_vld = 1'b0;
      drain("stream");

      // Reset in mid-operation with 16 sets in flight
      do_reset();
      bus.arg_vld = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.a = $urandom; bus.b = $urandom; bus.c = $urandom_range(0, 1000);
         @(negedge clk);
         @(posedge clk); #1;
      end
      check("midrst_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      bus.arg_vld = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_arg_rdy", 32'(bus.arg_rdy), 32'd1);
      res_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.res_vld) res_cnt++;
         @(negedge clk);
      end
      check("midrst_no_res", 32'(res_cnt), 32'd0);
      $display("mid-run reset: stray results=%0d", res_cnt);
      single_set(0, vecs[0]);

      // Random arg_vld, 200 sets against the reference model
      acc0 = n_accepts;
      res0 = n_results;
      sent = 0;
      guard = 0;
      while (sent < 200 && guard < 20000) begin
         bus.arg_vld = 1'($urandom_range(0, 1));
         bus.a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         bus.b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         bus.c = $urandom;
         @(negedge clk);
         if (bus.arg_vld && bus.arg_rdy) sent++;
         @(posedge clk); #1;
         guard++;
      end
      bus.arg_vld = 1'b0;
      check("random_sets_sent", 32'(sent), 32'd200);
      drain("random");
      check("random_results", 32'(n_results - res0), 32'(n_accepts - acc0));
      check("random_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("random: accepted=%0d returned=%0d", n_accepts - acc0, n_results - res0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/formula_2_recirc_sched.md
FORMULA_2_RECIRC_SCHED -- requirements
Module: formula_2_recirc_sched

Interface
REQ-001 Parameter ISQRT_STAGES, default 16: pipeline depth of the shared isqrt instance; y_vld follows x_vld by exactly ISQRT_STAGES cycles.
REQ-002 Parameter TAG_DEPTH, default ISQRT_STAGES: depth of the in-flight sideband FIFO; shall be >= ISQRT_STAGES.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 arg_vld  input  1  a/b/c valid this cycle.
REQ-006 arg_rdy  output  1  block accepts a/b/c this cycle; transfer when arg_vld && arg_rdy.
REQ-007 a, b, c  input  32 each  formula operands.
REQ-008 res_vld  output  1  one-cycle pulse, res valid; no back-pressure.
REQ-009 res  output  32  sqrt(a + sqrt(b + sqrt(c))), zero-extended from 16 bits.
REQ-010 busy  output  1  at least one argument set accepted whose result is not yet output.

Function
REQ-011 Block evaluates formula 2 using exactly one pipelined isqrt instance, time-multiplexed over three passes per argument set.
REQ-012 Pass encoding: P0 = sqrt(c), P1 = sqrt(b + y), P2 = sqrt(a + y); y = previous pass result.
REQ-013 On each isqrt issue, block pushes {pass, a, b} into sideband FIFO; on each y_vld, pops exactly one entry; both in same cycle allowed.
REQ-014 When y_vld && popped pass is P0 or P1: recirculate same cycle, x = (P0 ? b : a) + {16'b0, y}, x_vld = 1, push pass+1 with same a, b.
REQ-015 Recirculation has strict priority: arg_rdy = !(y_vld && popped pass != P2), combinational.
REQ-016 When arg_rdy && arg_vld: issue x = c, x_vld = 1, push {P0, a, b}.
REQ-017 When y_vld && popped pass == P2: res_vld = 1, res = {16'b0, y} same cycle; nothing issued from this slot unless a new argument is accepted.
REQ-018 Fixed latency: res_vld exactly 3*ISQRT_STAGES cycles after acceptance; results in acceptance order.
REQ-019 Additions are 32-bit, wrap modulo 2^32; no saturation.
REQ-020 In-flight counter: +1 on accept, -1 on res_vld, unchanged when both occur; busy = (count != 0); max count ISQRT_STAGES.
REQ-021 Steady continuous arg_vld: accept throughput is 1 set per 3 cycles on average (16 accept, 32 stall repeating for default).
REQ-022 FIFO never overflows and never pops empty; bench shall assert both; y_vld with FIFO empty is a design error.

Reset
REQ-023 While rst high: isqrt valid pipeline, sideband FIFO, in-flight counter cleared; res_vld = 0, busy = 0, arg_rdy = 1 in the cycle after rst deasserts.
REQ-024 rst mid-operation discards all in-flight work; no res_vld for any set accepted before reset.
REQ-025 res data value is don't-care while res_vld = 0.

Structure
REQ-026 Shared package formula_2_sched_pkg holds the pass enum (P0, P1, P2; 2-bit) and sideband struct {pass, a, b}.
REQ-027 Instantiates existing isqrt (n_pipe_stages = ISQRT_STAGES) and existing flip_flop_fifo_with_counter (width = 66, depth = TAG_DEPTH); no further sub-module.
REQ-028 No other isqrt instance; no shift-register alignment of a/b.

Verification
REQ-029 Single set a=9, b=12, c=16 -> res_vld once at cycle accept+48, res = 3; busy high 48 cycles.
REQ-030 Single set a=7, b=3, c=1 -> res = 3; a=b=c=0 -> res = 0.
REQ-031 Wrap: a=0, b=0xFFFF0000, c=0xFFFFFFFF -> passes 65535, 65535, res = 255.
REQ-032 arg_vld held high from reset, default stages -> arg_rdy high cycles 0-15, low 16-47, high 48-63, res_vld cycles 48-63, in order.
REQ-033 Random arg_vld 200 sets vs reference model -> all results match, in order, FIFO never over/underflows.
REQ-034 rst pulse at cycle 20 with 16 sets in flight -> no res_vld afterwards until new accepts; busy = 0, arg_rdy = 1 after reset.
